// File: rtl/ap_sequencer_pkg.sv
// Shared opcode encodings for the AP/data line issue stage.
// Opcodes are kept at their natural 3-bit width and cast where a wider opcode bus is used.
package ap_sequencer_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_AP_INC    = 3'd1;
    localparam logic [2:0] OP_AP_DEC    = 3'd2;
    localparam logic [2:0] OP_DATA_INC  = 3'd3;
    localparam logic [2:0] OP_DATA_DEC  = 3'd4;
    localparam logic [2:0] OP_TEST_ZERO = 3'd5;

endpackage

// File: rtl/ap_sequencer.sv
// Issue stage for the AP/data line: turns repeat-counted pointer/data instructions
// into single-cycle line requests, then reports completion, DataZero and AP underflow.
module ap_sequencer
    import ap_sequencer_pkg::*;
#(
    parameter int REPEAT_WIDTH = 8,
    parameter int OP_WIDTH     = 3
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    InsnValid,
    output logic                    InsnReady,
    input  logic [OP_WIDTH-1:0]     InsnOp,
    input  logic [REPEAT_WIDTH-1:0] InsnCount,
    output logic                    Done,
    output logic                    Zero,
    output logic                    Fault,
    input  logic                    FaultClear,
    output logic                    ApRequest,
    output logic                    DataRequest,
    output logic                    Dec,
    input  logic                    LineReady,
    input  logic                    DataZero,
    input  logic                    ApZero
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_ISSUE  = 5'b00010,
        S_SETTLE = 5'b00100,
        S_WAIT   = 5'b01000,
        S_FINISH = 5'b10000
    } state_t;

    state_t                  state_r;
    logic [OP_WIDTH-1:0]     op_r;
    logic [REPEAT_WIDTH-1:0] remaining_r;
    logic                    dec_r;
    logic                    done_r;
    logic                    zero_r;
    logic                    fault_r;

    logic                    accept_s;
    logic                    ap_req_s;
    logic                    data_req_s;
    logic                    underflow_s;

    function automatic logic is_dec_op(input logic [OP_WIDTH-1:0] op);
        return (op == OP_WIDTH'(OP_AP_DEC)) || (op == OP_WIDTH'(OP_DATA_DEC));
    endfunction

    function automatic logic is_line_op(input logic [OP_WIDTH-1:0] op);
        return (op == OP_WIDTH'(OP_AP_INC))   || (op == OP_WIDTH'(OP_AP_DEC)) ||
               (op == OP_WIDTH'(OP_DATA_INC)) || (op == OP_WIDTH'(OP_DATA_DEC));
    endfunction

    assign InsnReady   = (state_r == S_IDLE) && LineReady;
    assign accept_s    = InsnValid && InsnReady;
    assign ApRequest   = ap_req_s;
    assign DataRequest = data_req_s;
    assign Dec         = dec_r;
    assign Done        = done_r;
    assign Zero        = zero_r;
    assign Fault       = fault_r;

    // Request decode: pulses exist only in ISSUE, so a reset drops them at once.
    always_comb begin
        ap_req_s    = 1'b0;
        data_req_s  = 1'b0;
        underflow_s = 1'b0;
        if (state_r == S_ISSUE) begin
            if (op_r == OP_WIDTH'(OP_AP_INC)) begin
                ap_req_s = 1'b1;
            end else if (op_r == OP_WIDTH'(OP_AP_DEC)) begin
                if (ApZero) begin
                    underflow_s = 1'b1;
                end else begin
                    ap_req_s = 1'b1;
                end
            end else if ((op_r == OP_WIDTH'(OP_DATA_INC)) || (op_r == OP_WIDTH'(OP_DATA_DEC))) begin
                data_req_s = 1'b1;
            end else begin
                data_req_s = 1'b0;
            end
        end else begin
            ap_req_s = 1'b0;
        end
    end

    // Sequencer FSM, repeat counter and registered status outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= S_IDLE;
            op_r        <= {OP_WIDTH{1'b0}};
            remaining_r <= {REPEAT_WIDTH{1'b0}};
            dec_r       <= 1'b0;
            done_r      <= 1'b0;
            zero_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            // A new underflow outranks a simultaneous clear.
            if (underflow_s) begin
                fault_r <= 1'b1;
            end else if (FaultClear) begin
                fault_r <= 1'b0;
            end else begin
                fault_r <= fault_r;
            end

            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        op_r        <= InsnOp;
                        remaining_r <= InsnCount;
                        dec_r       <= is_dec_op(InsnOp);
                        if (is_line_op(InsnOp) && (InsnCount != {REPEAT_WIDTH{1'b0}})) begin
                            state_r <= S_ISSUE;
                        end else begin
                            state_r <= S_FINISH;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (underflow_s) begin
                        state_r <= S_FINISH;
                    end else begin
                        remaining_r <= remaining_r - REPEAT_WIDTH'(1);
                        state_r     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (!LineReady) begin
                        state_r <= S_WAIT;
                    end else if (remaining_r != {REPEAT_WIDTH{1'b0}}) begin
                        state_r <= S_ISSUE;
                    end else begin
                        state_r <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // Done is raised while still in FINISH so it never coincides with InsnReady.
                    if (done_r) begin
                        done_r  <= 1'b0;
                        dec_r   <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (LineReady) begin
                        done_r  <= 1'b1;
                        zero_r  <= DataZero;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    dec_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ap_sequencer.sv
// Directed bench for ap_sequencer with a small behavioural AP/data line model.
module tb_ap_sequencer;
    import ap_sequencer_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       InsnValid = 1'b0;
    logic       InsnReady;
    logic [2:0] InsnOp = 3'd0;
    logic [7:0] InsnCount = 8'd0;
    logic       Done, Zero, Fault;
    logic       FaultClear = 1'b0;
    logic       ApRequest, DataRequest, Dec;
    logic       LineReady, DataZero, ApZero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // line model state
    logic [7:0] ap_pos = 8'd1;
    logic [7:0] data_cell = 8'd1;
    int         busy_cnt = 0;
    int         busy_len = 0;
    logic       force_busy = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_ap = 8'd0;
    logic [7:0] load_data = 8'd0;

    // monitor counters
    logic clr_mon = 1'b0;
    int ap_pulses = 0, data_pulses = 0, dec_pulses = 0, both_high = 0;
    int req_busy = 0, done_cnt = 0, done_ready = 0;

    ap_sequencer #(.REPEAT_WIDTH(8), .OP_WIDTH(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InsnValid(InsnValid), .InsnReady(InsnReady),
        .InsnOp(InsnOp), .InsnCount(InsnCount), .Done(Done), .Zero(Zero), .Fault(Fault),
        .FaultClear(FaultClear), .ApRequest(ApRequest), .DataRequest(DataRequest), .Dec(Dec),
        .LineReady(LineReady), .DataZero(DataZero), .ApZero(ApZero)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        if (load_en) begin
            ap_pos    <= load_ap;
            data_cell <= load_data;
            busy_cnt  <= 0;
        end else begin
            if (ApRequest) ap_pos <= Dec ? ap_pos - 8'd1 : ap_pos + 8'd1;
            if (DataRequest) data_cell <= Dec ? data_cell - 8'd1 : data_cell + 8'd1;
            if (ApRequest || DataRequest) busy_cnt <= busy_len;
            else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        end
    end

    assign LineReady = (busy_cnt == 0) && !force_busy;
    assign ApZero    = (ap_pos == 8'd0);
    assign DataZero  = (data_cell == 8'd0);

    always @(posedge Clk) begin
        if (clr_mon) begin
            ap_pulses <= 0; data_pulses <= 0; dec_pulses <= 0; both_high <= 0;
            req_busy <= 0; done_cnt <= 0; done_ready <= 0;
        end else begin
            if (ApRequest) ap_pulses <= ap_pulses + 1;
            if (DataRequest) data_pulses <= data_pulses + 1;
            if ((ApRequest || DataRequest) && Dec) dec_pulses <= dec_pulses + 1;
            if (ApRequest && DataRequest) both_high <= both_high + 1;
            if ((ApRequest || DataRequest) && busy_cnt != 0) req_busy <= req_busy + 1;
            if (Done) done_cnt <= done_cnt + 1;
            if (Done && InsnReady) done_ready <= done_ready + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_line(input logic [7:0] ap, input logic [7:0] data, input int busy);
        load_ap = ap; load_data = data; busy_len = busy; load_en = 1'b1; clr_mon = 1'b1;
        @(negedge Clk);
        load_en = 1'b0; clr_mon = 1'b0;
    endtask

    // Waits (bounded) for InsnReady, offers one instruction, returns at the negedge after accept.
    task automatic send(input logic [2:0] op, input logic [7:0] cnt, output int t0);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (InsnReady === 1'b1) begin ok = 1'b1; break; end
            @(negedge Clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_timeout: InsnReady=%b required 1", InsnReady); end
        InsnValid = 1'b1; InsnOp = op; InsnCount = cnt; t0 = cyc;
        @(negedge Clk);
        InsnValid = 1'b0; InsnOp = OP_AP_DEC; InsnCount = 8'hFF;
    endtask

    task automatic wait_done(output int t, output logic z, output logic d);
        bit ok = 1'b0;
        t = -1; z = 1'bx; d = 1'bx;
        for (int i = 0; i < 300; i++) begin
            if (Done === 1'b1) begin ok = 1'b1; t = cyc; z = Zero; d = Dec; break; end
            @(negedge Clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL done_timeout: Done=%b required 1", Done); end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        checks++;
        if ({ApRequest, DataRequest, Dec, Done, Zero, Fault} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b required 000000",
                {ApRequest, DataRequest, Dec, Done, Zero, Fault});
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (InsnReady !== 1'b1) begin errors++; $display("FAIL reset_ready: InsnReady=%b required 1", InsnReady); end
    endtask

    task automatic test_reset_mid_issue;
        int t0;
        load_line(8'd5, 8'd0, 4);
        send(OP_DATA_DEC, 8'd3, t0);
        checks++;
        if ({DataRequest, Dec} !== 2'b11) begin errors++; $display("FAIL issue_before_reset: got %b required 11", {DataRequest, Dec}); end
        #1 Rst_n = 1'b0;
        #1;
        checks++;
        if ({ApRequest, DataRequest, Dec, Done, Zero, Fault} !== 6'b0) begin
            errors++; $display("FAIL reset_mid_issue: got %b required 000000",
                {ApRequest, DataRequest, Dec, Done, Zero, Fault});
        end
        @(negedge Clk);
        force_busy = 1'b1; Rst_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (InsnReady !== 1'b0) begin errors++; $display("FAIL ready_busy_line: InsnReady=%b required 0", InsnReady); end
        force_busy = 1'b0;
        #1;
        checks++;
        if (InsnReady !== 1'b1) begin errors++; $display("FAIL ready_idle_line: InsnReady=%b required 1", InsnReady); end
        @(negedge Clk);
    endtask

    task automatic test_single_latency;
        int t0, t; logic z, d;
        load_line(8'd0, 8'd0, 0);
        send(OP_DATA_INC, 8'd1, t0);
        wait_done(t, z, d);
        checks++;
        if (t - t0 !== 5) begin errors++; $display("FAIL single_latency: got %0d cycles required 5", t - t0); end
        checks++;
        if (z !== 1'b0) begin errors++; $display("FAIL single_zero: Zero=%b required 0", z); end
        @(negedge Clk);
    endtask

    task automatic test_data_inc;
        int t0, t; logic z, d;
        load_line(8'd0, 8'd253, 4);
        send(OP_DATA_INC, 8'd3, t0);
        wait_done(t, z, d);
        repeat (3) @(negedge Clk);
        checks++;
        if (t - t0 !== 20) begin errors++; $display("FAIL data_inc_latency: got %0d cycles required 20", t - t0); end
        checks++;
        if (z !== 1'b1) begin errors++; $display("FAIL data_inc_zero: Zero=%b required 1", z); end
        checks++;
        if ({data_pulses, ap_pulses, dec_pulses} !== {32'd3, 32'd0, 32'd0}) begin
            errors++; $display("FAIL data_inc_pulses: data=%0d ap=%0d dec=%0d required 3 0 0", data_pulses, ap_pulses, dec_pulses);
        end
        checks++;
        if ({req_busy, both_high, done_cnt} !== {32'd0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL data_inc_protocol: busy_req=%0d both=%0d done=%0d required 0 0 1", req_busy, both_high, done_cnt);
        end
    endtask

    task automatic test_ap_underflow;
        int t0, t; logic z, d;
        load_line(8'd2, 8'd7, 2);
        send(OP_AP_DEC, 8'd5, t0);
        wait_done(t, z, d);
        checks++;
        if (t - t0 !== 11) begin errors++; $display("FAIL ap_dec_latency: got %0d cycles required 11", t - t0); end
        checks++;
        if ({d, z, Fault} !== 3'b101) begin errors++; $display("FAIL ap_dec_status: dec,zero,fault=%b required 101", {d, z, Fault}); end
        @(negedge Clk);
        checks++;
        if (Dec !== 1'b0) begin errors++; $display("FAIL dec_release: Dec=%b required 0", Dec); end
        repeat (3) @(negedge Clk);
        checks++;
        if ({ap_pulses, dec_pulses, data_pulses, done_cnt} !== {32'd2, 32'd2, 32'd0, 32'd1} || ap_pos !== 8'd0) begin
            errors++; $display("FAIL ap_dec_pulses: ap=%0d dec=%0d data=%0d done=%0d pos=%0d required 2 2 0 1 0",
                ap_pulses, dec_pulses, data_pulses, done_cnt, ap_pos);
        end
    endtask

    task automatic test_test_zero;
        int t0, t; logic z, d;
        load_line(8'd3, 8'd0, 3);
        send(OP_TEST_ZERO, 8'd4, t0);
        wait_done(t, z, d);
        checks++;
        if (z !== 1'b1 || t - t0 !== 2) begin errors++; $display("FAIL test_zero_set: Zero=%b lat=%0d required 1 2", z, t - t0); end
        @(negedge Clk);
        load_line(8'd3, 8'd9, 3);
        send(OP_TEST_ZERO, 8'd4, t0);
        wait_done(t, z, d);
        repeat (2) @(negedge Clk);
        checks++;
        if (z !== 1'b0 || t - t0 !== 2) begin errors++; $display("FAIL test_zero_clear: Zero=%b lat=%0d required 0 2", z, t - t0); end
        checks++;
        if (ap_pulses + data_pulses !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL test_zero_requests: req=%0d done=%0d required 0 1", ap_pulses + data_pulses, done_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int t0, t1, t2, t3; logic z, d;
        load_line(8'd4, 8'd4, 0);
        send(OP_DATA_INC, 8'd0, t0);
        wait_done(t1, z, d);
        InsnValid = 1'b1; InsnOp = 3'd7; InsnCount = 8'd5;
        @(negedge Clk);
        checks++;
        if (InsnReady !== 1'b1) begin errors++; $display("FAIL b2b_ready: InsnReady=%b required 1", InsnReady); end
        @(negedge Clk);
        wait_done(t2, z, d);
        InsnOp = OP_NOP; InsnCount = 8'd0;
        @(negedge Clk);
        @(negedge Clk);
        InsnValid = 1'b0;
        wait_done(t3, z, d);
        repeat (3) @(negedge Clk);
        checks++;
        if (t1 - t0 !== 2 || t2 - t1 !== 3 || t3 - t2 !== 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d %0d %0d required 2 3 3", t1 - t0, t2 - t1, t3 - t2);
        end
        checks++;
        if (ap_pulses + data_pulses !== 0 || done_cnt !== 3 || done_ready !== 0) begin
            errors++; $display("FAIL b2b_activity: req=%0d done=%0d overlap=%0d required 0 3 0",
                ap_pulses + data_pulses, done_cnt, done_ready);
        end
    endtask

    task automatic test_fault_clear;
        int t0, t; logic z, d;
        checks++;
        if (Fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: Fault=%b required 1", Fault); end
        FaultClear = 1'b1;
        @(negedge Clk);
        FaultClear = 1'b0;
        checks++;
        if (Fault !== 1'b0) begin errors++; $display("FAIL fault_clear: Fault=%b required 0", Fault); end
        load_line(8'd0, 8'd1, 2);
        send(OP_AP_DEC, 8'd1, t0);
        FaultClear = 1'b1;
        checks++;
        if (ApRequest !== 1'b0) begin errors++; $display("FAIL underflow_no_pulse: ApRequest=%b required 0", ApRequest); end
        @(negedge Clk);
        FaultClear = 1'b0;
        checks++;
        if (Fault !== 1'b1) begin errors++; $display("FAIL set_beats_clear: Fault=%b required 1", Fault); end
        wait_done(t, z, d);
        repeat (2) @(negedge Clk);
        checks++;
        if (Fault !== 1'b1 || ap_pulses !== 0) begin errors++; $display("FAIL fault_hold: Fault=%b ap=%0d required 1 0", Fault, ap_pulses); end
        FaultClear = 1'b1;
        @(negedge Clk);
        FaultClear = 1'b0;
        checks++;
        if (Fault !== 1'b0) begin errors++; $display("FAIL late_clear: Fault=%b required 0", Fault); end
    endtask

    initial begin
        test_reset;
        test_reset_mid_issue;
        test_single_latency;
        test_data_inc;
        test_ap_underflow;
        test_test_zero;
        test_back_to_back;
        test_fault_clear;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
